irq_aggregator: RTL
===================

IRQ_AGGREGATOR -- requirements
Module: irq_aggregator

Interface
REQ-001 SHALL have parameter N_SRC, default 16, number of interrupt sources (range 2..32).
REQ-002 SHALL have port clk_i  input  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port src_i  input  N_SRC  peripheral interrupt lines, synchronous to clk_i; a rising edge marks an event.
REQ-005 SHALL have port src_mask_i  input  N_SRC  per-source enable; 1 = source may be forwarded.
REQ-006 SHALL have port irq_take_i  input  1  pulse from the interrupt controller: the request was accepted this cycle.
REQ-007 SHALL have port irq_ret_i  input  1  pulse from the interrupt controller: the handler returned (mret of an interrupt).
REQ-008 SHALL have port irq_req_o  output  1  interrupt request to the controller.
REQ-009 SHALL have port irq_id_o  output  5  index of the source being requested or serviced.
REQ-010 SHALL have port irq_pending_o  output  N_SRC  pending-bit vector, for software readback.
REQ-011 SHALL have port irq_busy_o  output  1  high while in state SERVICE.

Function
REQ-012 SHALL keep a previous-value register src_q per source; pending[i] is set when src_i[i]=1 and src_q[i]=0 at a clock edge.
REQ-013 SHALL keep an event as pending even when src_mask_i[i]=0; the mask gates only forwarding.
REQ-014 SHALL implement three states: IDLE, REQ, SERVICE; all outputs are registered.
REQ-015 In IDLE, when (pending & src_mask_i) != 0, SHALL latch the lowest set index into irq_id_o and enter REQ at the next edge.
REQ-016 SHALL drive irq_req_o=1 exactly while in REQ; irq_id_o SHALL stay stable in REQ and SERVICE.
REQ-017 In REQ with irq_take_i=1, SHALL clear pending[irq_id_o], drop irq_req_o and enter SERVICE at the same edge.
REQ-018 In REQ with irq_take_i=0 and src_mask_i[irq_id_o]=0, SHALL withdraw the request (back to IDLE) and leave pending unchanged.
REQ-019 In SERVICE, irq_ret_i=1 SHALL return the block to IDLE; the next arbitration occurs in IDLE one cycle later.
REQ-020 SHALL ignore irq_ret_i in IDLE and REQ, and SHALL ignore irq_take_i in IDLE and SERVICE.
REQ-021 If an edge on source i coincides with the clearing of pending[i], set SHALL win: pending[i] stays 1.
REQ-022 Edges that arrive during REQ or SERVICE SHALL accumulate in pending; multiple edges on one source before service collapse into one pending bit.
REQ-023 Arbitration is fixed priority, index 0 highest; there is no fairness guarantee.
REQ-024 Latency: a source edge sampled at edge k sets pending after k; irq_req_o rises after edge k+1 (when IDLE and masked in).
REQ-025 irq_id_o SHALL be zero-extended to 5 bits when N_SRC < 32.

Reset
REQ-026 On rst_i=1 (asynchronously) SHALL force state=IDLE, pending=0, src_q=0, irq_req_o=0, irq_id_o=0, irq_busy_o=0.
REQ-027 A source held high while rst_i deasserts SHALL register as an edge on the first clock after reset.
REQ-028 Reset asserted in REQ or SERVICE SHALL abort the transaction and discard all pending events.

Verification
REQ-029 Single event: src_i[3] 0->1 with mask=all ones -> irq_req_o=1 two edges later, irq_id_o=3; take pulse -> irq_req_o=0, irq_busy_o=1, pending[3]=0; ret pulse -> irq_busy_o=0.
REQ-030 Priority: edges on sources 5 and 2 in the same cycle -> id=2 serviced first; after ret, id=5 requested, pending=0x0020 during the second REQ.
REQ-031 Masked event: edge on source 7 with mask[7]=0 -> pending[7]=1, no request; set mask[7]=1 -> irq_req_o=1, id=7 one cycle later.
REQ-032 Withdraw: in REQ for id=4, clear mask[4] without a take -> irq_req_o=0 next edge, state IDLE, pending[4] still 1.
REQ-033 Collision: new edge on source 1 in the same cycle as a take for id=1 -> pending[1]=1 after SERVICE is entered; request reissued after ret.
REQ-034 Async reset: assert rst_i mid-SERVICE between clock edges -> outputs go to 0 immediately, with no clock edge required.

Source files
------------

// File: rtl/irq_aggregator_if.sv
// Interrupt aggregator bus: peripheral lines and mask in, controller handshake both ways.
interface irq_aggregator_if #(
  parameter int unsigned N_SRC = 16
);
  logic [N_SRC-1:0] src_i;
  logic [N_SRC-1:0] src_mask_i;
  logic             irq_take_i;
  logic             irq_ret_i;
  logic             irq_req_o;
  logic [4:0]       irq_id_o;
  logic [N_SRC-1:0] irq_pending_o;
  logic             irq_busy_o;

  modport master (
    output src_i, src_mask_i, irq_take_i, irq_ret_i,
    input  irq_req_o, irq_id_o, irq_pending_o, irq_busy_o
  );

  modport slave (
    input  src_i, src_mask_i, irq_take_i, irq_ret_i,
    output irq_req_o, irq_id_o, irq_pending_o, irq_busy_o
  );
endinterface

// File: rtl/irq_aggregator.sv
// Edge-detecting interrupt aggregator: latches source events as pending bits and
// forwards the lowest-index enabled one to the controller via a req/take/ret handshake.
module irq_aggregator #(
  parameter int unsigned N_SRC = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  irq_aggregator_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t           state_q;
  logic [N_SRC-1:0] src_q;
  logic [N_SRC-1:0] pending_q;
  logic [N_SRC-1:0] pending_d;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] clr;
  logic [N_SRC-1:0] cand;
  logic [31:0]      mask_ext;
  logic [4:0]       id_q;
  logic [4:0]       sel_id;
  logic             req_q;
  logic             busy_q;
  logic             take_fire;

  // Pending update: new edges are OR'd in after the clear so a coinciding edge survives.
  always_comb begin
    rise      = bus.src_i & ~src_q;
    mask_ext  = 32'(bus.src_mask_i);
    take_fire = (state_q == REQ) && bus.irq_take_i;
    clr       = '0;
    if (take_fire) clr = N_SRC'(32'd1 << id_q);
    pending_d = (pending_q & ~clr) | rise;
    cand      = pending_q & bus.src_mask_i;
    sel_id    = '0;
    for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
      if (cand[i]) sel_id = 5'(i);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      src_q     <= '0;
      pending_q <= '0;
      id_q      <= '0;
      req_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      src_q     <= bus.src_i;
      pending_q <= pending_d;
      case (state_q)
        IDLE: begin
          if (|cand) begin
            id_q    <= sel_id;
            req_q   <= 1'b1;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (bus.irq_take_i) begin
            req_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= SERVICE;
          end else if (!mask_ext[id_q]) begin
            // Source was masked off while waiting: withdraw, keep it pending.
            req_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        SERVICE: begin
          if (bus.irq_ret_i) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          req_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.irq_req_o     = req_q;
  assign bus.irq_id_o      = id_q;
  assign bus.irq_pending_o = pending_q;
  assign bus.irq_busy_o    = busy_q;

endmodule
